// File: rtl/sdrc_req_arb_pkg.sv
// Shared SDRAM controller definitions: arbiter state encodings and port count.
package sdrc_req_arb_pkg;

  localparam int SDR_NUM_PORTS  = 4;
  localparam int SDR_PORT_IDX_W = 2;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/sdrc_req_arb_rr_pick.sv
// Rotating-priority selector: first requester at or above the start index, wrapping mod 4.
module sdrc_rr_pick
  import sdrc_req_arb_pkg::*;
(
  input  logic [SDR_NUM_PORTS-1:0]  req_i,
  input  logic [SDR_PORT_IDX_W-1:0] start_i,
  input  logic                      fixed_i,
  output logic                      valid_o,
  output logic [SDR_PORT_IDX_W-1:0] winner_o
);

  logic [SDR_PORT_IDX_W-1:0] base;
  logic [SDR_PORT_IDX_W-1:0] cand;

  // Scan from the farthest offset down so the closest requester to base is written last.
  always_comb begin
    valid_o  = 1'b0;
    winner_o = '0;
    cand     = '0;
    base     = fixed_i ? '0 : start_i;
    for (int i = SDR_NUM_PORTS - 1; i >= 0; i--) begin
      cand = base + SDR_PORT_IDX_W'(i);
      if (req_i[cand]) begin
        valid_o  = 1'b1;
        winner_o = cand;
      end
    end
  end

endmodule

// File: rtl/sdrc_req_arb.sv
// Four-port request arbiter in front of the SDRAM request generator.
module sdrc_req_arb
  import sdrc_req_arb_pkg::*;
#(
  parameter int APP_AW   = 30,
  parameter int APP_RW   = 9,
  parameter int REQ_ID_W = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          cfg_fixed_pri,
  input  logic [3:0]                    p_req,
  input  logic [4*(APP_AW+1)-1:0]       p_addr,
  input  logic [4*(APP_AW-1)-1:0]       p_addr_mask,
  input  logic [4*APP_RW-1:0]           p_len,
  input  logic [3:0]                    p_wr_n,
  input  logic [3:0]                    p_wrap,
  output logic [3:0]                    p_ack,
  output logic                          req,
  output logic [REQ_ID_W-1:0]           req_id,
  output logic [APP_AW:0]               req_addr,
  output logic [APP_AW-2:0]             req_addr_mask,
  output logic [APP_RW-1:0]             req_len,
  output logic                          req_wr_n,
  output logic                          req_wrap,
  input  logic                          req_ack,
  output logic                          arb_busy,
  output logic [1:0]                    arb_grant
);

  // Handshake: req is valid while in GRANT and the granted port still requests;
  // a transfer happens in any cycle where req & req_ack, and p_ack echoes it the same cycle.

  arb_state_e                state_q, state_d;
  logic [SDR_PORT_IDX_W-1:0] arb_grant_q, arb_grant_d;
  logic [SDR_PORT_IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  logic                      pick_valid;
  logic [SDR_PORT_IDX_W-1:0] pick_idx;

  logic [APP_AW:0]   addr_arr [SDR_NUM_PORTS];
  logic [APP_AW-2:0] mask_arr [SDR_NUM_PORTS];
  logic [APP_RW-1:0] len_arr  [SDR_NUM_PORTS];

  for (genvar g = 0; g < SDR_NUM_PORTS; g++) begin : g_unpack
    assign addr_arr[g] = p_addr[g*(APP_AW+1) +: APP_AW+1];
    assign mask_arr[g] = p_addr_mask[g*(APP_AW-1) +: APP_AW-1];
    assign len_arr[g]  = p_len[g*APP_RW +: APP_RW];
  end

  sdrc_rr_pick u_pick (
    .req_i    (p_req),
    .start_i  (rr_ptr_q),
    .fixed_i  (cfg_fixed_pri),
    .valid_o  (pick_valid),
    .winner_o (pick_idx)
  );

  assign req      = (state_q == ARB_GRANT) & p_req[arb_grant_q];
  assign arb_busy = (state_q == ARB_GRANT);
  assign arb_grant = arb_grant_q;

  // Fields are never captured; the requester holds them until p_ack.
  assign req_id        = REQ_ID_W'(arb_grant_q);
  assign req_addr      = addr_arr[arb_grant_q];
  assign req_addr_mask = mask_arr[arb_grant_q];
  assign req_len       = len_arr[arb_grant_q];
  assign req_wr_n      = p_wr_n[arb_grant_q];
  assign req_wrap      = p_wrap[arb_grant_q];

  always_comb begin
    p_ack = '0;
    if (req && req_ack) p_ack[arb_grant_q] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    arb_grant_d = arb_grant_q;
    rr_ptr_d    = rr_ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          arb_grant_d = pick_idx;
          state_d     = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (req && req_ack) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = arb_grant_q + 2'd1;
        end else if (!p_req[arb_grant_q]) begin
          // Abort: the requester withdrew, so the pointer does not advance.
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ARB_IDLE;
      arb_grant_q <= '0;
      rr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      arb_grant_q <= arb_grant_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_sdrc_req_arb.sv
// Directed bench for sdrc_req_arb: per-cycle vector table plus hand-written corner sequences.
module tb_sdrc_req_arb;

  localparam int AW  = 30;
  localparam int RW  = 9;
  localparam int IDW = 4;

  logic              clk;
  logic              reset_n;
  logic              cfg_fixed_pri;
  logic [3:0]        p_req;
  logic [4*(AW+1)-1:0] p_addr;
  logic [4*(AW-1)-1:0] p_addr_mask;
  logic [4*RW-1:0]   p_len;
  logic [3:0]        p_wr_n;
  logic [3:0]        p_wrap;
  logic [3:0]        p_ack;
  logic              req;
  logic [IDW-1:0]    req_id;
  logic [AW:0]       req_addr;
  logic [AW-2:0]     req_addr_mask;
  logic [RW-1:0]     req_len;
  logic              req_wr_n;
  logic              req_wrap;
  logic              req_ack;
  logic              arb_busy;
  logic [1:0]        arb_grant;

  sdrc_req_arb #(.APP_AW(AW), .APP_RW(RW), .REQ_ID_W(IDW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cfg_fixed_pri (cfg_fixed_pri),
    .p_req         (p_req),
    .p_addr        (p_addr),
    .p_addr_mask   (p_addr_mask),
    .p_len         (p_len),
    .p_wr_n        (p_wr_n),
    .p_wrap        (p_wrap),
    .p_ack         (p_ack),
    .req           (req),
    .req_id        (req_id),
    .req_addr      (req_addr),
    .req_addr_mask (req_addr_mask),
    .req_len       (req_len),
    .req_wr_n      (req_wr_n),
    .req_wrap      (req_wrap),
    .req_ack       (req_ack),
    .arb_busy      (arb_busy),
    .arb_grant     (arb_grant)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- port field constants ----------------
  logic [AW:0]   addr_tab [4];
  logic [AW-2:0] mask_tab [4];
  logic [RW-1:0] len_tab  [4];

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit       do_rst;
    bit       fixed;
    bit [3:0] preq;
    bit       ack;
    bit       e_req;
    bit [3:0] e_ack;
    bit       e_busy;
    bit [1:0] e_grant;
    bit [1:0] e_rr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input bit rst, input bit fx, input bit [3:0] pr, input bit ak,
                     input bit er, input bit [3:0] ea, input bit eb,
                     input bit [1:0] eg, input bit [1:0] err);
    vec_t v;
    v.do_rst = rst; v.fixed = fx; v.preq = pr; v.ack = ak;
    v.e_req = er; v.e_ack = ea; v.e_busy = eb; v.e_grant = eg; v.e_rr = err;
    vq.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    p_req   = 4'b0000;
    req_ack = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic drive(input bit fx, input bit [3:0] pr, input bit ak);
    @(posedge clk); #1;
    cfg_fixed_pri = fx;
    p_req         = pr;
    req_ack       = ak;
  endtask

  task automatic check_core(input string tag, input bit er, input bit [3:0] ea,
                            input bit eb, input bit [1:0] eg, input bit [1:0] err);
    check({tag, " req"},       32'(req),          32'(er));
    check({tag, " p_ack"},     32'(p_ack),        32'(ea));
    check({tag, " arb_busy"},  32'(arb_busy),     32'(eb));
    check({tag, " arb_grant"}, 32'(arb_grant),    32'(eg));
    check({tag, " req_id"},    32'(req_id),       32'(eg));
    check({tag, " rr_ptr"},    32'(dut.rr_ptr_q), 32'(err));
  endtask

  task automatic check_fields(input string tag, input bit [1:0] port);
    check({tag, " req_addr"},  32'(req_addr),      32'(addr_tab[port]));
    check({tag, " req_mask"},  32'(req_addr_mask), 32'(mask_tab[port]));
    check({tag, " req_len"},   32'(req_len),       32'(len_tab[port]));
    check({tag, " req_wr_n"},  32'(req_wr_n),      32'(p_wr_n[port]));
    check({tag, " req_wrap"},  32'(req_wrap),      32'(p_wrap[port]));
  endtask

  // ---------------- test ----------------
  initial begin
    reset_n = 1'b0; cfg_fixed_pri = 1'b0; p_req = '0; req_ack = 1'b0;
    addr_tab[0] = 31'h1000_0010; addr_tab[1] = 31'h2000_0220;
    addr_tab[2] = 31'h3000_0330; addr_tab[3] = 31'h0000_0123;
    mask_tab[0] = 29'h00AA; mask_tab[1] = 29'h0155;
    mask_tab[2] = 29'h00F0; mask_tab[3] = 29'h000F;
    len_tab[0]  = 9'h010; len_tab[1] = 9'h020; len_tab[2] = 9'h040; len_tab[3] = 9'h1F0;
    p_wr_n = 4'b1010;
    p_wrap = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      p_addr[i*(AW+1) +: AW+1]    = addr_tab[i];
      p_addr_mask[i*(AW-1) +: AW-1] = mask_tab[i];
      p_len[i*RW +: RW]           = len_tab[i];
    end

    // Single request on port 2 straight out of reset.
    add(1, 0, 4'b0100, 1, 0, 4'b0000, 0, 2'd0, 2'd0);
    add(0, 0, 4'b0100, 1, 1, 4'b0100, 1, 2'd2, 2'd0);
    add(0, 0, 4'b0000, 1, 0, 4'b0000, 0, 2'd2, 2'd3);
    // Round-robin over all four ports: grants 0,1,2,3,0, one acceptance per 2 cycles.
    add(1, 0, 4'b1111, 1, 0, 4'b0000, 0, 2'd0, 2'd0);
    add(0, 0, 4'b1111, 1, 1, 4'b0001, 1, 2'd0, 2'd0);
    add(0, 0, 4'b1111, 1, 0, 4'b0000, 0, 2'd0, 2'd1);
    add(0, 0, 4'b1111, 1, 1, 4'b0010, 1, 2'd1, 2'd1);
    add(0, 0, 4'b1111, 1, 0, 4'b0000, 0, 2'd1, 2'd2);
    add(0, 0, 4'b1111, 1, 1, 4'b0100, 1, 2'd2, 2'd2);
    add(0, 0, 4'b1111, 1, 0, 4'b0000, 0, 2'd2, 2'd3);
    add(0, 0, 4'b1111, 1, 1, 4'b1000, 1, 2'd3, 2'd3);
    add(0, 0, 4'b1111, 1, 0, 4'b0000, 0, 2'd3, 2'd0);
    add(0, 0, 4'b1111, 1, 1, 4'b0001, 1, 2'd0, 2'd0);
    // Fixed priority: port 1 wins every time over port 3.
    add(1, 1, 4'b1010, 1, 0, 4'b0000, 0, 2'd0, 2'd0);
    add(0, 1, 4'b1010, 1, 1, 4'b0010, 1, 2'd1, 2'd0);
    add(0, 1, 4'b1010, 1, 0, 4'b0000, 0, 2'd1, 2'd2);
    add(0, 1, 4'b1010, 1, 1, 4'b0010, 1, 2'd1, 2'd2);
    add(0, 1, 4'b1010, 1, 0, 4'b0000, 0, 2'd1, 2'd2);
    add(0, 1, 4'b1010, 1, 1, 4'b0010, 1, 2'd1, 2'd2);
    // Abort: port 0 stalls 5 cycles then withdraws; ack high on the drop cycle must not ack.
    add(1, 0, 4'b0001, 0, 0, 4'b0000, 0, 2'd0, 2'd0);
    for (int i = 0; i < 5; i++) add(0, 0, 4'b0001, 0, 1, 4'b0000, 1, 2'd0, 2'd0);
    add(0, 0, 4'b0000, 1, 0, 4'b0000, 1, 2'd0, 2'd0);
    add(0, 0, 4'b0000, 0, 0, 4'b0000, 0, 2'd0, 2'd0);

    foreach (vq[k]) begin
      if (vq[k].do_rst) do_reset();
      drive(vq[k].fixed, vq[k].preq, vq[k].ack);
      @(negedge clk);
      check_core($sformatf("vec%0d", k), vq[k].e_req, vq[k].e_ack, vq[k].e_busy,
                 vq[k].e_grant, vq[k].e_rr);
      if (vq[k].e_req) check_fields($sformatf("vec%0d", k), vq[k].e_grant);
    end

    // Port 3 fields stay selected while port 0 joins mid-grant.
    do_reset();
    drive(0, 4'b1000, 0);
    @(negedge clk);
    check_core("p3 idle", 0, 4'b0000, 0, 2'd0, 2'd0);
    drive(0, 4'b1000, 0);
    @(negedge clk);
    check_core("p3 grant", 1, 4'b0000, 1, 2'd3, 2'd0);
    check("p3 req_len", 32'(req_len), 32'h1F0);
    check("p3 req_addr", 32'(req_addr), 32'h123);
    drive(0, 4'b1001, 0);
    @(negedge clk);
    check_core("p3 hold", 1, 4'b0000, 1, 2'd3, 2'd0);
    check("p3 hold req_len", 32'(req_len), 32'h1F0);
    check("p3 hold req_addr", 32'(req_addr), 32'h123);
    drive(0, 4'b1001, 1);
    @(negedge clk);
    check_core("p3 accept", 1, 4'b1000, 1, 2'd3, 2'd0);
    drive(0, 4'b0001, 0);
    @(negedge clk);
    check_core("p3 after", 0, 4'b0000, 0, 2'd3, 2'd0);

    // Reset pulse while port 2 holds the grant.
    do_reset();
    drive(0, 4'b0100, 0);
    drive(0, 4'b0100, 0);
    @(negedge clk);
    check_core("rst pre", 1, 4'b0000, 1, 2'd2, 2'd0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check_core("rst post", 0, 4'b0000, 0, 2'd0, 2'd0);
    drive(0, 4'b0100, 1);
    @(negedge clk);
    check_core("rst resume", 1, 4'b0100, 1, 2'd2, 2'd0);
    drive(0, 4'b0000, 1);
    @(negedge clk);
    check_core("rst done", 0, 4'b0000, 0, 2'd2, 2'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdrc_req_arb.md
SDRC_REQ_ARB -- requirements
Module: sdrc_req_arb

Interface
REQ-001 Parameters SHALL be:
- APP_AW, default 30, application address width; address buses are APP_AW+1 bits.
- APP_RW, default 9, request length width.
- REQ_ID_W, default 4, request ID width (equals `SDR_REQ_ID_W).
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  clock.
- reset_n  in  1  synchronous, active-low reset.
- cfg_fixed_pri  in  1  0 = round-robin; 1 = fixed priority, port 0 highest.
- p_req  in  4  per-port request.
- p_addr  in  4*(APP_AW+1)  packed per-port address; port n at [n*(APP_AW+1) +: APP_AW+1].
- p_addr_mask  in  4*(APP_AW-1)  packed per-port address mask.
- p_len  in  4*APP_RW  packed per-port length.
- p_wr_n  in  4  per-port 0=write, 1=read.
- p_wrap  in  4  per-port wrap mode.
- p_ack  out  4  one-hot, single-cycle acceptance.
- req  out  1  to request generator.
- req_id  out  REQ_ID_W  to request generator.
- req_addr  out  APP_AW+1  to request generator.
- req_addr_mask  out  APP_AW-1  to request generator.
- req_len  out  APP_RW  to request generator.
- req_wr_n  out  1  to request generator.
- req_wrap  out  1  to request generator.
- req_ack  in  1  from request generator; may be combinational from req.
- arb_busy  out  1  high while in GRANT.
- arb_grant  out  2  index of the current or last granted port.

Function
REQ-003 FSM SHALL have two states, IDLE and GRANT.
REQ-004 IDLE: if p_req != 0, the winner SHALL be registered into arb_grant and the FSM SHALL move to GRANT; otherwise it stays in IDLE.
REQ-005 Round-robin mode: search SHALL start at rr_ptr and proceed upward mod 4; the first requesting port wins.
REQ-006 Fixed mode: the lowest-index requesting port SHALL win; rr_ptr is not used for selection.
REQ-007 req SHALL equal (state==GRANT) & p_req[arb_grant], combinationally.
REQ-008 In GRANT, the req_* fields SHALL be a combinational mux of port arb_grant.
REQ-009 req_id SHALL be {zeros, arb_grant}, i.e. the port index in bits [1:0].
REQ-010 p_ack[arb_grant] SHALL equal req & req_ack, same cycle; all other p_ack bits SHALL be 0.
REQ-011 On req & req_ack: FSM SHALL return to IDLE next cycle, and rr_ptr SHALL load arb_grant+1 mod 4, in both modes.
REQ-012 If p_req[arb_grant] drops in GRANT before acceptance (abort): req SHALL fall the same cycle, FSM SHALL return to IDLE, and rr_ptr SHALL be unchanged.
REQ-013 Latency: p_req rising at cycle N with FSM in IDLE SHALL give req=1 at cycle N+1; minimum one IDLE cycle between grants, so at most one acceptance every 2 cycles.
REQ-014 While in GRANT, new or changed p_req on other ports SHALL NOT alter arb_grant.
REQ-015 Requesters SHALL hold p_req and their fields stable until p_ack; the arbiter does not capture fields.
REQ-016 arb_busy SHALL equal (state==GRANT).

Reset
REQ-017 While reset_n=0 at a clk edge, the following SHALL clear:
- state=IDLE, rr_ptr=0, arb_grant=0.
- Resulting outputs: req=0, p_ack=0, arb_busy=0, req_id=0.
REQ-018 Reset asserted mid-GRANT SHALL drop req in the cycle following the reset edge; no p_ack is produced for the aborted grant.

Structure
REQ-019 State encodings (ARB_IDLE, ARB_GRANT) and the port count constant (4) SHALL live in the shared sdrc definitions file with the other controller macros.
REQ-020 The rotating priority selector SHALL be one sub-module, sdrc_rr_pick: inputs request vector, start pointer and fixed flag; outputs a valid flag and a 2-bit winner index.

Verification
REQ-021 Scenarios the bench SHALL cover (stimulus -> required response):
- Reset, then p_req=4'b0100, req_ack tied high -> req=1 one cycle later with req_id=2, p_ack=4'b0100 for exactly one cycle, rr_ptr=3.
- Round-robin, p_req=4'b1111 held with req_ack high -> grant order 0,1,2,3,0; one acceptance every 2 cycles.
- cfg_fixed_pri=1, p_req=4'b1010 held with req_ack high -> port 1 granted repeatedly; port 3 never granted.
- Port 0 granted with req_ack low for 5 cycles, then p_req[0] dropped -> req falls the same cycle, no p_ack, rr_ptr stays 0, FSM in IDLE next cycle.
- Port 3 granted, p_len[3]=9'h1F0 and p_addr[3]=0x123 -> req_len=9'h1F0, req_addr=0x123, req_id=3; p_req[0] asserted mid-grant does not change the outputs.
- reset_n pulsed low during GRANT -> req=0, p_ack=0 and arb_grant=0 after the edge; normal arbitration resumes after release.
